// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : wb_pkg
// Description : Shared state encoding and default parameters for s_wb_mem.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int C_ADDR_WIDTH  = 32;
    localparam int C_DATA_WIDTH  = 64;
    localparam int C_DEPTH_LOG2  = 8;
    localparam int C_WAIT_CYCLES = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ACK  = 2'b10
    } wb_state_t;

    // Word-address LSB for a bus of the given data width.
    function automatic int addr_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/s_wb_mem_if.sv
`default_nettype none
// ============================================================================
// Interface   : s_wb_mem_if
// Description : Pipelined Wishbone bus bundle between a master and s_wb_mem.
// Revision    : 1.0 - initial release
// ============================================================================
interface s_wb_mem_if
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = C_ADDR_WIDTH,
    parameter int DATA_WIDTH = C_DATA_WIDTH
);
    localparam int BYTE_WIDTH   = DATA_WIDTH / 8;
    localparam int WBS_ADDR_LSB = addr_lsb(DATA_WIDTH);

    logic                               s_wb_cyc;
    logic                               s_wb_stb;
    logic                               s_wb_we;
    logic [ADDR_WIDTH-1:WBS_ADDR_LSB]   s_wb_adr;
    logic [DATA_WIDTH-1:0]              s_wb_dat_i;
    logic [BYTE_WIDTH-1:0]              s_wb_sel;
    logic [DATA_WIDTH-1:0]              s_wb_dat_o;
    logic                               s_wb_ack;
    logic                               s_wb_stall;

    modport master (
        output s_wb_cyc, s_wb_stb, s_wb_we, s_wb_adr, s_wb_dat_i, s_wb_sel,
        input  s_wb_dat_o, s_wb_ack, s_wb_stall
    );

    modport slave (
        input  s_wb_cyc, s_wb_stb, s_wb_we, s_wb_adr, s_wb_dat_i, s_wb_sel,
        output s_wb_dat_o, s_wb_ack, s_wb_stall
    );

endinterface
`default_nettype wire

// File: rtl/s_wb_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : s_wb_mem_array
// Description : Single-port synchronous RAM with byte enables; read data is
//               registered and held until the next read.
// Revision    : 1.0 - initial release
// ============================================================================
module s_wb_mem_array
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int DEPTH_LOG2 = C_DEPTH_LOG2
) (
    input  wire                     clk,
    input  wire                     en,
    input  wire                     we,
    input  wire [DATA_WIDTH/8-1:0]  sel,
    input  wire [DEPTH_LOG2-1:0]    addr,
    input  wire [DATA_WIDTH-1:0]    wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int C_BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [2**DEPTH_LOG2];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < C_BYTES; b++) begin
                    if (sel[b]) begin
                        r_mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[addr];
            end
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/s_wb_mem.sv
`default_nettype none
// ============================================================================
// Module      : s_wb_mem
// Description : Wishbone slave memory with programmable wait states, abort on
//               cyc drop and a sticky out-of-range error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module s_wb_mem
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH  = C_ADDR_WIDTH,
    parameter int DATA_WIDTH  = C_DATA_WIDTH,
    parameter int DEPTH_LOG2  = C_DEPTH_LOG2,
    parameter int WAIT_CYCLES = C_WAIT_CYCLES
) (
    input  wire         aclk,
    input  wire         aresetn,
    s_wb_mem_if.slave   s_wb,
    output logic        oob_err
);

    localparam int          BYTE_WIDTH   = DATA_WIDTH / 8;
    localparam int          WBS_ADDR_LSB = addr_lsb(DATA_WIDTH);
    localparam int          WORD_AW      = ADDR_WIDTH - WBS_ADDR_LSB;
    localparam logic [3:0]  C_WAIT       = 4'(WAIT_CYCLES);

    wb_state_t              r_state;
    wb_state_t              w_state_nxt;
    logic [3:0]             r_cnt;

    logic                   r_we;
    logic [WORD_AW-1:0]     r_adr;
    logic [DATA_WIDTH-1:0]  r_dat;
    logic [BYTE_WIDTH-1:0]  r_sel;

    logic                   r_dato_zero;
    logic                   r_oob_err;

    logic                   w_accept;
    logic                   w_commit;
    logic                   w_c_we;
    logic [WORD_AW-1:0]     w_c_adr;
    logic [DATA_WIDTH-1:0]  w_c_dat;
    logic [BYTE_WIDTH-1:0]  w_c_sel;
    logic                   w_c_oob;
    logic [DATA_WIDTH-1:0]  w_rdata;

    assign w_accept = (r_state == ST_IDLE) && s_wb.s_wb_cyc && s_wb.s_wb_stb;

    always_comb begin
        w_state_nxt = ST_IDLE;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (WAIT_CYCLES == 0) begin
                        w_state_nxt = ST_ACK;
                        w_commit    = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!s_wb.s_wb_cyc) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt <= 4'd1) begin
                    w_state_nxt = ST_ACK;
                    w_commit    = 1'b1;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_ACK:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A zero-wait commit happens on the accept edge, so it uses the live bus.
    assign w_c_we  = (r_state == ST_IDLE) ? s_wb.s_wb_we    : r_we;
    assign w_c_adr = (r_state == ST_IDLE) ? s_wb.s_wb_adr   : r_adr;
    assign w_c_dat = (r_state == ST_IDLE) ? s_wb.s_wb_dat_i : r_dat;
    assign w_c_sel = (r_state == ST_IDLE) ? s_wb.s_wb_sel   : r_sel;
    assign w_c_oob = |(w_c_adr >> DEPTH_LOG2);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_dato_zero <= 1'b1;
            r_oob_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt <= C_WAIT;
            end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit && !w_c_we) begin
                r_dato_zero <= w_c_oob;
            end
            if (w_commit && w_c_oob) begin
                r_oob_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_accept) begin
            r_we  <= s_wb.s_wb_we;
            r_adr <= s_wb.s_wb_adr;
            r_dat <= s_wb.s_wb_dat_i;
            r_sel <= s_wb.s_wb_sel;
        end
    end

    s_wb_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (aclk),
        .en    (w_commit && !w_c_oob),
        .we    (w_c_we),
        .sel   (w_c_sel),
        .addr  (w_c_adr[DEPTH_LOG2-1:0]),
        .wdata (w_c_dat),
        .rdata (w_rdata)
    );

    assign s_wb.s_wb_ack   = (r_state == ST_ACK);
    assign s_wb.s_wb_stall = (r_state == ST_WAIT);
    assign s_wb.s_wb_dat_o = r_dato_zero ? '0 : w_rdata;
    assign oob_err         = r_oob_err;

endmodule
`default_nettype wire

// File: tb/tb_s_wb_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_s_wb_mem
// Description : Randomized bench for s_wb_mem at WAIT_CYCLES 1, 3 and 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_s_wb_mem;

    logic        aclk = 1'b0;
    logic        aresetn;

    logic        cyc   [3];
    logic        stb   [3];
    logic        we    [3];
    logic [28:0] adr   [3];
    logic [63:0] dat_i [3];
    logic [7:0]  sel   [3];
    logic        ack   [3];
    logic        stall [3];
    logic [63:0] dat_o [3];
    logic        oob   [3];

    int          waits [3] = '{1, 3, 0};

    logic [63:0] m_mem  [3][256];
    logic [63:0] m_dato [3];
    bit          m_oob  [3];

    int          n_vec = 0;
    int          n_err = 0;

    always #5 aclk = ~aclk;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            localparam int W = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
            s_wb_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) u_bus ();
            assign u_bus.s_wb_cyc   = cyc[g];
            assign u_bus.s_wb_stb   = stb[g];
            assign u_bus.s_wb_we    = we[g];
            assign u_bus.s_wb_adr   = adr[g];
            assign u_bus.s_wb_dat_i = dat_i[g];
            assign u_bus.s_wb_sel   = sel[g];
            assign ack[g]   = u_bus.s_wb_ack;
            assign stall[g] = u_bus.s_wb_stall;
            assign dat_o[g] = u_bus.s_wb_dat_o;
            s_wb_mem #(
                .ADDR_WIDTH  (32),
                .DATA_WIDTH  (64),
                .DEPTH_LOG2  (8),
                .WAIT_CYCLES (W)
            ) u_dut (
                .aclk    (aclk),
                .aresetn (aresetn),
                .s_wb    (u_bus.slave),
                .oob_err (oob[g])
            );
        end
    endgenerate

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One transaction on DUT k, starting and ending on a falling edge.
    // classic: hold stb until ack is seen; abort_at: cycle to drop cyc (-1 none).
    task automatic txn(input int k, input bit w, input logic [28:0] a, input logic [63:0] d,
                       input logic [7:0] s, input bit classic, input int abort_at);
        int lat = 0;
        bit got = 1'b0;
        bit oob_a;
        int idx;
        oob_a = (a > 29'd255);
        idx   = int'(a[7:0]);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; dat_i[k] = d; sel[k] = s;
        @(posedge aclk);
        while (!got && lat < 20) begin
            @(negedge aclk);
            lat++;
            if (!classic) stb[k] = 1'b0;
            if (lat == abort_at) begin
                check_val("abort_stall", 64'(stall[k]), 64'd1);
                cyc[k] = 1'b0; stb[k] = 1'b0;
                @(negedge aclk);
                check_val("abort_ack", 64'(ack[k]), 64'd0);
                check_val("abort_stall_clr", 64'(stall[k]), 64'd0);
                return;
            end
            if (ack[k]) got = 1'b1;
            else check_val("wait_stall", 64'(stall[k]), 64'd1);
        end
        check_val("ack_latency", 64'(lat), 64'(waits[k] + 1));
        if (got) begin
            check_val("ack_stall", 64'(stall[k]), 64'd0);
            if (w) begin
                if (!oob_a) begin
                    for (int b = 0; b < 8; b++) begin
                        if (s[b]) m_mem[k][idx][b*8 +: 8] = d[b*8 +: 8];
                    end
                end
            end else begin
                m_dato[k] = oob_a ? 64'd0 : m_mem[k][idx];
            end
            if (oob_a) m_oob[k] = 1'b1;
            check_val("dat_o", dat_o[k], m_dato[k]);
            check_val("oob_err", 64'(oob[k]), 64'(m_oob[k]));
        end
        if (classic) begin
            @(negedge aclk);
            check_val("tail_ack", 64'(ack[k]), 64'd0);
            check_val("tail_stall", 64'(stall[k]), 64'd0);
        end
        cyc[k] = 1'b0; stb[k] = 1'b0;
        @(negedge aclk);
        check_val("no_dup_ack", 64'(ack[k]), 64'd0);
        check_val("idle_stall", 64'(stall[k]), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        int          ab;
        logic [28:0] a;
        aresetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
            adr[i] = '0; dat_i[i] = '0; sel[i] = '0;
            m_dato[i] = 64'd0; m_oob[i] = 1'b0;
        end
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        for (int i = 0; i < 3; i++) begin
            check_val("rst_ack", 64'(ack[i]), 64'd0);
            check_val("rst_stall", 64'(stall[i]), 64'd0);
            check_val("rst_dat_o", dat_o[i], 64'd0);
            check_val("rst_oob", 64'(oob[i]), 64'd0);
        end
        aresetn = 1'b1;
        @(negedge aclk);

        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 48; j++) begin
                txn(i, 1'b1, 29'(j), {$urandom, $urandom}, 8'hFF, 1'b0, -1);
            end
        end

        // Full and partial write at word 0x10
        txn(0, 1'b1, 29'h10, 64'h1122334455667788, 8'hFF, 1'b1, -1);
        txn(0, 1'b0, 29'h10, 64'd0, 8'h00, 1'b1, -1);
        check_val("rd_full", dat_o[0], 64'h1122334455667788);
        txn(0, 1'b1, 29'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b0, -1);
        txn(0, 1'b0, 29'h10, 64'd0, 8'h00, 1'b0, -1);
        check_val("rd_partial", dat_o[0], 64'h11223344AAAAAAAA);

        txn(1, 1'b0, 29'h05, 64'd0, 8'h00, 1'b0, -1);
        txn(2, 1'b0, 29'h05, 64'd0, 8'h00, 1'b1, -1);

        // Out-of-range read and write alias onto word 0 if the range check fails
        txn(0, 1'b0, 29'h100, 64'd0, 8'h00, 1'b1, -1);
        repeat (5) @(negedge aclk);
        check_val("oob_sticky", 64'(oob[0]), 64'd1);
        txn(0, 1'b1, 29'h100, {$urandom, $urandom}, 8'hFF, 1'b0, -1);
        txn(0, 1'b0, 29'h000, 64'd0, 8'h00, 1'b0, -1);

        txn(0, 1'b1, 29'h20, {$urandom, $urandom}, 8'hFF, 1'b0, 1);
        txn(0, 1'b0, 29'h20, 64'd0, 8'h00, 1'b0, -1);

        // Reset in the middle of a wait on DUT 1
        txn(1, 1'b0, 29'h1FF, 64'd0, 8'h00, 1'b0, -1);
        txn(1, 1'b0, 29'h21, 64'd0, 8'h00, 1'b0, -1);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 29'h20;
        dat_i[1] = ~m_mem[1][32]; sel[1] = 8'hFF;
        @(posedge aclk);
        @(negedge aclk);
        check_val("pre_rst_stall", 64'(stall[1]), 64'd1);
        aresetn = 1'b0;
        @(negedge aclk);
        check_val("midrst_ack", 64'(ack[1]), 64'd0);
        check_val("midrst_stall", 64'(stall[1]), 64'd0);
        check_val("midrst_dat_o", dat_o[1], 64'd0);
        check_val("midrst_oob", 64'(oob[1]), 64'd0);
        aresetn = 1'b1; cyc[1] = 1'b0; stb[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_dato[i] = 64'd0; m_oob[i] = 1'b0;
        end
        @(negedge aclk);
        txn(1, 1'b0, 29'h20, 64'd0, 8'h00, 1'b1, -1);

        repeat (300) begin
            k = int'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) a = 29'($urandom) | 29'h100;
            else a = 29'($urandom_range(0, 47));
            ab = -1;
            if (waits[k] > 0 && $urandom_range(0, 7) == 0) ab = int'($urandom_range(1, waits[k]));
            txn(k, 1'($urandom), a, {$urandom, $urandom}, 8'($urandom), 1'($urandom), ab);
            repeat ($urandom_range(0, 2)) @(negedge aclk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/s_wb_mem.md
S_WB_MEM -- requirements
Module: s_wb_mem

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64: data width; BYTE_WIDTH = DATA_WIDTH/8; WBS_ADDR_LSB = clog2(BYTE_WIDTH).
REQ-003 SHALL have parameter DEPTH_LOG2, default 8: memory holds 2^DEPTH_LOG2 words.
REQ-004 SHALL have parameter WAIT_CYCLES, default 1, range 0..15: wait states between accept and ack.
REQ-005 SHALL have port aclk, input, 1: clock, all logic on rising edge.
REQ-006 SHALL have port aresetn, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port s_wb_cyc, input, 1: cycle valid.
REQ-008 SHALL have port s_wb_stb, input, 1: strobe.
REQ-009 SHALL have port s_wb_we, input, 1: 1 = write, 0 = read.
REQ-010 SHALL have port s_wb_adr, input, [ADDR_WIDTH-1:WBS_ADDR_LSB]: word address.
REQ-011 SHALL have port s_wb_dat_i, input, DATA_WIDTH: write data.
REQ-012 SHALL have port s_wb_sel, input, BYTE_WIDTH: byte enables.
REQ-013 SHALL have port s_wb_dat_o, output reg, DATA_WIDTH: read data.
REQ-014 SHALL have port s_wb_ack, output, 1: one-cycle acknowledge.
REQ-015 SHALL have port s_wb_stall, output, 1: back-pressure.
REQ-016 SHALL have port oob_err, output reg, 1: sticky out-of-range flag.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, ACK.
- IDLE: stall=0, ack=0.
- WAIT: stall=1, ack=0.
- ACK: stall=0, ack=1.
REQ-018 SHALL accept a request only in IDLE with cyc=1 and stb=1, latching adr, dat_i, sel and we.
REQ-019 On accept, SHALL load the wait counter with WAIT_CYCLES and go to WAIT; if WAIT_CYCLES=0, SHALL go directly to ACK (ack in the cycle after accept).
REQ-020 In WAIT, SHALL decrement the counter each cycle and move to ACK in the cycle after it reaches 1; total latency from accept edge to ack = WAIT_CYCLES+1 cycles.
REQ-021 SHALL commit the access on the edge that enters ACK:
- Write: update only the bytes with latched sel=1.
- Read: register the word into s_wb_dat_o.
REQ-022 s_wb_dat_o SHALL hold its value outside ACK until the next read commits; writes SHALL NOT change it.
REQ-023 ACK SHALL last exactly one cycle and always return to IDLE; cyc&stb in ACK SHALL be treated as the tail of the acknowledged request and not accepted. This makes the slave compatible with classic masters that hold stb until ack is seen with stall low.
REQ-024 If cyc falls while in WAIT, SHALL abort to IDLE next cycle: no commit, no ack.
REQ-025 stb=1 with cyc=0 SHALL be ignored.
REQ-026 Out-of-range access (address word index >= 2^DEPTH_LOG2) SHALL still be acknowledged with normal latency:
- Writes discarded.
- Reads return all zeros.
- oob_err set to 1 and held until reset.
REQ-027 Memory index SHALL be the low DEPTH_LOG2 bits of s_wb_adr after the range check; no wrap-around aliasing.
REQ-028 Illegal FSM encoding SHALL return to IDLE next cycle with ack=0 and stall=0.

Reset
REQ-029 While aresetn=0 at a clock edge, SHALL force: state=IDLE, counter=0, s_wb_dat_o=0, oob_err=0, ack=0, stall=0.
REQ-030 Reset asserted mid-transaction SHALL drop it with no commit and no ack.
REQ-031 Memory contents SHALL NOT be cleared by reset; read-before-write contents are undefined.

Structure
REQ-032 State encodings (IDLE=2'b00, WAIT=2'b01, ACK=2'b10) and default parameter values SHALL live in shared package wb_pkg.
REQ-033 Storage SHALL be sub-module s_wb_mem_array:
- Single-port, synchronous, byte-enabled.
- Ports: clk, en, we, sel, addr, wdata, rdata.
REQ-034 FSM, range check and counter SHALL be in s_wb_mem; s_wb_ack and s_wb_stall decode combinationally from state.

Verification
REQ-035 Parameters (64-bit, WAIT_CYCLES=1): write adr=0x10, dat=0x1122334455667788, sel=0xFF, then read adr=0x10 -> ack 2 cycles after each accept; read data 0x1122334455667788; stall=1 for one cycle per request.
REQ-036 Partial write sel=0x0F, dat=0xAAAAAAAAAAAAAAAA over 0x1122334455667788 at adr 0x10, then read -> 0x11223344AAAAAAAA.
REQ-037 WAIT_CYCLES=3, read request -> stall high 3 cycles, ack on the 4th cycle after accept; WAIT_CYCLES=0 -> ack on the 1st cycle, stall never high.
REQ-038 Read adr=0x100 with DEPTH_LOG2=8 -> ack with data 0; oob_err=1 and still 1 after 5 idle cycles; memory word 0x00 unchanged.
REQ-039 Drop cyc during WAIT on a write to 0x20 -> no ack; later read of 0x20 returns its prior value; aresetn low mid-WAIT -> ack=0, dat_o=0, oob_err=0 next cycle.
REQ-040 Back-to-back: classic master holding stb through ack, then new request 2 cycles later -> exactly one commit per request, no duplicate ack.
